reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width (16 entries).
REQ-003 SHALL have ports clk in 1, system clock; rst in 1, reset; rdy in 1, ready, pause when low.
REQ-004 The reset rst SHALL be asynchronous and active-high, and the block SHALL use the single clock clk.
REQ-005 SHALL have port commit_en in 1: ROB commit valid (driven by ROB_Ready).
REQ-006 SHALL have port commit_addr in 5: destination register (ROB_Addr).
REQ-007 SHALL have port commit_value in XLEN: result (ROB_Value).
REQ-008 SHALL have port commit_tag in TAG_W: ROB entry of committing instruction (ROB_Tag).
REQ-009 SHALL have port rename_en in 1: issue stage claims a destination.
REQ-010 SHALL have port rename_addr in 5: register being renamed.
REQ-011 SHALL have port rename_tag in TAG_W: ROB entry now producing that register.
REQ-012 SHALL have port flush in 1: misprediction, discard all renames.
REQ-013 SHALL have ports rs1_addr and rs2_addr, each in 5: operand selects.
REQ-014 SHALL have ports rs1_value and rs2_value, each out XLEN: operand values.
REQ-015 SHALL have ports rs1_busy and rs2_busy, each out 1: operand pending in ROB.
REQ-016 SHALL have ports rs1_tag and rs2_tag, each out TAG_W: producing ROB entry, valid when busy.

Function
REQ-017 SHALL hold 32 x XLEN registers, 32 busy bits, and 32 x TAG_W tags.
REQ-018 All state updates SHALL occur on posedge clk only when rdy=1; with rdy=0 the state holds.
REQ-019 Register x0 SHALL read 0 with busy=0 and tag=0; commit and rename to x0 SHALL be ignored.
REQ-020 On commit_en, regs[commit_addr] SHALL take commit_value at the next edge, regardless of the busy bit.
REQ-021 On commit_en, busy[commit_addr] SHALL clear only if it is set and tags[commit_addr]==commit_tag; on a tag mismatch (newer rename) busy and tag SHALL be kept.
REQ-022 On rename_en, busy[rename_addr] SHALL be set to 1 and tags[rename_addr] set to rename_tag at the next edge.
REQ-023 When commit and rename target the same address in one cycle, the value SHALL be written and busy/tag SHALL take the rename (rename wins).
REQ-024 Reads SHALL be combinational, zero latency.
REQ-025 Read bypass: if commit_en, commit_addr==rsX_addr!=0, the register is busy, and its tag==commit_tag, the read SHALL return commit_value with busy=0.
REQ-026 A rename in the same cycle SHALL NOT affect same-cycle reads; reads show the pre-rename state, so an instruction reading its own rd sees the old producer.
REQ-027 On flush, all busy bits SHALL clear at the next edge, a same-cycle commit value SHALL still be written, and a same-cycle rename SHALL be ignored.
REQ-028 Tags SHALL be unchanged by flush; they are don't-care while busy=0.
REQ-029 Bypass per REQ-025 SHALL still apply during a flush cycle.

Reset
REQ-030 While rst=1, regardless of clk and rdy, all regs SHALL be 0, all busy 0 and all tags 0; outputs therefore read 0/0/0.
REQ-031 Deassertion of rst mid-operation SHALL discard any in-flight commit or rename that was presented during reset.

Verification
REQ-032 The bench SHALL cover rename x5 tag 3, then commit x5 tag 3 value 0xDEADBEEF -> the read after the rename gives busy=1 tag=3; during the commit cycle the read gives 0xDEADBEEF busy=0; after the edge busy=0.
REQ-033 The bench SHALL cover rename x7 tag 2, rename x7 tag 9, then commit x7 tag 2 value 0x11 -> regs[x7]=0x11, busy=1, tag=9, and no bypass in the commit cycle.
REQ-034 The bench SHALL cover a same-cycle commit x4 tag 1 value 0x22 (x4 busy tag 1) with rename x4 tag 6 -> after the edge value 0x22, busy=1, tag=6; the same-cycle read shows 0x22 busy=0.
REQ-035 The bench SHALL cover a write, rename, and read of x0 with value 0x55 and tag 4 -> the read gives 0, busy 0, tag 0 at all times.
REQ-036 The bench SHALL cover x1..x3 busy, then flush with commit x2 value 0x7 and rename x9 tag 5 -> all busy=0, regs[x2]=0x7, x9 not busy.
REQ-037 The bench SHALL cover rdy=0 with commit x6 value 0x99 -> no change; asserting rst asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with rename (busy/tag) tracking for a ROB-based core.
// Commit writes values and retires busy bits; rename claims destinations; reads are combinational with commit bypass.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             commit_en,
  input  logic [4:0]       commit_addr,
  input  logic [XLEN-1:0]  commit_value,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             rename_en,
  input  logic [4:0]       rename_addr,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic             flush,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_value,
  output logic [XLEN-1:0]  rs2_value,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag
);

  localparam int NREG = 32;

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [TAG_W-1:0] tags_q [NREG];
  logic [TAG_W-1:0] tags_d [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;

  logic commit_wr_s;
  logic commit_match_s;
  logic rename_wr_s;

  logic [4:0]       rd_addr_s  [2];
  logic [XLEN-1:0]  rd_value_s [2];
  logic             rd_busy_s  [2];
  logic [TAG_W-1:0] rd_tag_s   [2];

  // x0 is hardwired: neither commit nor rename may touch it
  assign commit_wr_s    = commit_en && (commit_addr != 5'd0);
  assign commit_match_s = commit_wr_s && busy_q[commit_addr] &&
                          (tags_q[commit_addr] == commit_tag);
  assign rename_wr_s    = rename_en && (rename_addr != 5'd0) && !flush;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tags_d = tags_q;
    if (commit_wr_s) begin
      regs_d[commit_addr] = commit_value;
    end else begin
      regs_d[0] = '0;
    end
    if (flush) begin
      busy_d = '0;
    end else begin
      // rename is applied last so it wins over a same-address retire
      if (commit_match_s) begin
        busy_d[commit_addr] = 1'b0;
      end else begin
        busy_d[0] = 1'b0;
      end
      if (rename_wr_s) begin
        busy_d[rename_addr] = 1'b1;
        tags_d[rename_addr] = rename_tag;
      end else begin
        busy_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tags_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy) begin
      regs_q <= regs_d;
      tags_q <= tags_d;
      busy_q <= busy_d;
    end
  end

  assign rd_addr_s[0] = rs1_addr;
  assign rd_addr_s[1] = rs2_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd_value_s[p] = regs_q[rd_addr_s[p]];
      rd_busy_s[p]  = busy_q[rd_addr_s[p]];
      rd_tag_s[p]   = tags_q[rd_addr_s[p]];
      if (rd_addr_s[p] == 5'd0) begin
        rd_value_s[p] = '0;
        rd_busy_s[p]  = 1'b0;
        rd_tag_s[p]   = '0;
      end else if (commit_match_s && (commit_addr == rd_addr_s[p])) begin
        rd_value_s[p] = commit_value;
        rd_busy_s[p]  = 1'b0;
      end else begin
        rd_busy_s[p]  = busy_q[rd_addr_s[p]];
      end
    end
  end

  assign rs1_value = rd_value_s[0];
  assign rs1_busy  = rd_busy_s[0];
  assign rs1_tag   = rd_tag_s[0];
  assign rs2_value = rd_value_s[1];
  assign rs2_busy  = rd_busy_s[1];
  assign rs2_tag   = rd_tag_s[1];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a driver predicts read responses from an array model, a monitor compares.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        commit_en = 1'b0;
  logic [4:0]  commit_addr = 5'd0;
  logic [31:0] commit_value = 32'd0;
  logic [3:0]  commit_tag = 4'd0;
  logic        rename_en = 1'b0;
  logic [4:0]  rename_addr = 5'd0;
  logic [3:0]  rename_tag = 4'd0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic [31:0] rs1_value, rs2_value;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;

  reg_file #(.XLEN(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .commit_en(commit_en), .commit_addr(commit_addr), .commit_value(commit_value),
    .commit_tag(commit_tag), .rename_en(rename_en), .rename_addr(rename_addr),
    .rename_tag(rename_tag), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  a1, a2;
    logic [31:0] v1, v2;
    logic        b1, b2;
    logic [3:0]  t1, t2;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: plain arrays following the architectural rules
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 4'd0;
    end
  endfunction

  function automatic bit m_retire_ok(input logic [4:0] a);
    return commit_en && a != 5'd0 && a == commit_addr && m_busy[a] && m_tag[a] == commit_tag;
  endfunction

  task automatic m_read(input logic [4:0] a, output logic [31:0] v, output logic b, output logic [3:0] t);
    if (a == 5'd0) begin v = 32'd0; b = 1'b0; t = 4'd0; end
    else if (m_retire_ok(a)) begin v = commit_value; b = 1'b0; t = m_tag[a]; end
    else begin v = m_regs[a]; b = m_busy[a]; t = m_tag[a]; end
  endtask

  // What the next clock edge does to the architectural state
  function automatic void m_edge();
    bit retire;
    if (rst || !rdy) return;
    retire = m_retire_ok(commit_addr);
    if (commit_en && commit_addr != 5'd0) m_regs[commit_addr] = commit_value;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (retire) m_busy[commit_addr] = 1'b0;
      if (rename_en && rename_addr != 5'd0) begin
        m_busy[rename_addr] = 1'b1;
        m_tag[rename_addr]  = rename_tag;
      end
    end
  endfunction

  task automatic drive(input string nm, input bit ce, input logic [4:0] ca, input logic [31:0] cv,
                       input logic [3:0] ct, input bit re, input logic [4:0] ra, input logic [3:0] rt,
                       input bit fl, input bit rd, input bit rs, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    commit_en = ce; commit_addr = ca; commit_value = cv; commit_tag = ct;
    rename_en = re; rename_addr = ra; rename_tag = rt;
    flush = fl; rdy = rd; rs1_addr = a1; rs2_addr = a2;
    #2;
    rst = rs;
    if (rs) m_clear();
    e.name = nm; e.a1 = a1; e.a2 = a2;
    m_read(a1, e.v1, e.b1, e.t1);
    m_read(a2, e.v2, e.b2, e.t2);
    exp_q.push_back(e);
    m_edge();
  endtask

  task automatic idle(input string nm, input logic [4:0] a1, input logic [4:0] a2);
    drive(nm, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, a1, a2);
  endtask

  task automatic check_port(input string nm, input int p, input logic [4:0] a,
                            input logic [31:0] av, input logic ab, input logic [3:0] at,
                            input logic [31:0] ev, input logic eb, input logic [3:0] et);
    bit tag_care;
    tag_care = eb || (a == 5'd0);
    n_cmp++;
    if (av !== ev || ab !== eb || (tag_care && at !== et)) begin
      n_fail++;
      $display("FAIL %s rs%0d(x%0d): got value=%h busy=%b tag=%0d, want value=%h busy=%b tag=%0d",
               nm, p, a, av, ab, at, ev, eb, et);
    end
  endtask

  // Monitor: reads are sampled mid-cycle against the queued prediction
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_port(e.name, 1, e.a1, rs1_value, rs1_busy, rs1_tag, e.v1, e.b1, e.t1);
      check_port(e.name, 2, e.a2, rs2_value, rs2_busy, rs2_tag, e.v2, e.b2, e.t2);
    end
  end

  initial begin
    logic [4:0] ca, ra;
    m_clear();
    drive("reset", 1'b1, 5'd3, 32'h1234, 4'd0, 1'b1, 5'd3, 4'd1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd0);
    idle("after_reset", 5'd3, 5'd5);

    drive("ren_x5", 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd5, 4'd3, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0);
    idle("x5_busy", 5'd5, 5'd0);
    drive("commit_x5_bypass", 1'b1, 5'd5, 32'hDEADBEEF, 4'd3, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd5);
    idle("x5_done", 5'd5, 5'd0);

    drive("ren_x7_t2", 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd7, 4'd2, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0);
    drive("ren_x7_t9", 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd7, 4'd9, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0);
    drive("commit_x7_stale", 1'b1, 5'd7, 32'h11, 4'd2, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0);
    idle("x7_after", 5'd7, 5'd0);

    drive("ren_x4_t1", 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd4, 4'd1, 1'b0, 1'b1, 1'b0, 5'd4, 5'd0);
    drive("commit_ren_x4", 1'b1, 5'd4, 32'h22, 4'd1, 1'b1, 5'd4, 4'd6, 1'b0, 1'b1, 1'b0, 5'd4, 5'd4);
    idle("x4_after", 5'd4, 5'd0);

    drive("x0_write", 1'b1, 5'd0, 32'h55, 4'd4, 1'b1, 5'd0, 4'd4, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    idle("x0_after", 5'd0, 5'd0);

    drive("ren_x1", 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd1, 4'd1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0);
    drive("ren_x2", 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd2, 4'd2, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2);
    drive("ren_x3", 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd3, 4'd3, 1'b0, 1'b1, 1'b0, 5'd2, 5'd3);
    drive("flush", 1'b1, 5'd2, 32'h7, 4'd2, 1'b1, 5'd9, 4'd5, 1'b1, 1'b1, 1'b0, 5'd2, 5'd3);
    idle("flush_x1_x2", 5'd1, 5'd2);
    idle("flush_x3_x9", 5'd3, 5'd9);

    drive("rdy_low", 1'b1, 5'd6, 32'h99, 4'd0, 1'b1, 5'd6, 4'd2, 1'b0, 1'b0, 1'b0, 5'd6, 5'd0);
    idle("rdy_low_after", 5'd6, 5'd0);
    drive("async_rst", 1'b1, 5'd8, 32'hAB, 4'd0, 1'b1, 5'd8, 4'd7, 1'b0, 1'b1, 1'b1, 5'd2, 5'd4);
    idle("rst_release", 5'd8, 5'd7);

    for (int i = 0; i < 400; i++) begin
      ca = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      drive("random", $urandom_range(0, 99) < 50, ca, $urandom,
            ($urandom_range(0, 99) < 70) ? m_tag[ca] : 4'($urandom),
            $urandom_range(0, 99) < 50, ra, 4'($urandom),
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 85,
            $urandom_range(0, 199) == 0,
            ($urandom_range(0, 99) < 40) ? ca : 5'($urandom), 5'($urandom));
    end
    idle("tail", 5'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
